// File: rtl/band_matvec_pkg.sv
// Shared constants, state type and constant-multiply helper for the banded
// Toeplitz matrix-vector engine.
package band_matvec_pkg;

  localparam int N  = 16;
  localparam int XW = 32;
  localparam int BW = 16;
  localparam int AW = 38;

  // Band coefficients by distance from the diagonal: +C0, -C1, +C2, -C3.
  localparam int C0 = 20;
  localparam int C1 = 13;
  localparam int C2 = 6;
  localparam int C3 = 1;

  localparam logic signed [AW-1:0] RND     = AW'(1 << 15);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (BW-1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_t;

  // Constant multiply built from shifted copies; k is a small elaboration-time constant.
  function automatic logic signed [AW-1:0] mul_k(input logic signed [AW-1:0] v, input int k);
    logic signed [AW-1:0] acc;
    acc = '0;
    for (int b = 0; b < 5; b++) begin
      if (((k >> b) & 1) != 0) acc = acc + (v <<< b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/band_matvec_row_pipe.sv
// Two-stage row arithmetic: partial band sums, then round, shift and saturate.
// Stage 1 holds p (centre and +-1 taps) and q (+-2, +-3 taps) at full 38-bit precision.
module band_row_pipe #(
  parameter int XW = band_matvec_pkg::XW,
  parameter int BW = band_matvec_pkg::BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tap_valid,
  input  logic [6:0][XW-1:0] taps,
  output logic [BW-1:0]      b_out,
  output logic               out_valid
);
  import band_matvec_pkg::*;

  logic signed [AW-1:0] t [7];
  logic signed [AW-1:0] p_d, q_d, p_q, q_q;
  logic signed [AW-1:0] s, sh;
  logic [BW-1:0]        b_d;
  logic                 v1;

  for (genvar g = 0; g < 7; g++) begin : g_ext
    assign t[g] = AW'($signed(taps[g]));
  end

  assign p_d = mul_k(t[3], C0) - mul_k(t[2] + t[4], C1);
  assign q_d = mul_k(t[1] + t[5], C2) - mul_k(t[0] + t[6], C3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1  <= 1'b0;
      p_q <= '0;
      q_q <= '0;
    end else begin
      v1 <= tap_valid;
      if (tap_valid) begin
        p_q <= p_d;
        q_q <= q_d;
      end
    end
  end

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    s  = p_q + q_q + RND;
    sh = s >>> 16;
    b_d = BW'(sh);
    if (sh > SAT_MAX)      b_d = BW'(SAT_MAX);
    else if (sh < SAT_MIN) b_d = BW'(SAT_MIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      b_out     <= '0;
    end else begin
      out_valid <= v1;
      if (v1) b_out <= b_d;
    end
  end

endmodule

// File: rtl/band_matvec.sv
// Loads an N-element Q16.16 vector, then streams b = A*x for the 7-wide band
// matrix through a two-stage row pipeline.
//   state | meaning
//   LOAD  | accept x_in into buffer[wr_idx] on each in_valid
//   CALC  | issue rows 0..N-1 into the pipe, one per cycle; in_valid ignored
module band_matvec #(
  parameter int N  = band_matvec_pkg::N,
  parameter int XW = band_matvec_pkg::XW,
  parameter int BW = band_matvec_pkg::BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [XW-1:0] x_in,
  output logic          busy,
  output logic          out_valid,
  output logic [BW-1:0] b_out
);
  import band_matvec_pkg::*;

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        wr_idx_q, wr_idx_d;
  logic [IW-1:0]        issue_idx_q, issue_idx_d;
  logic                 buf_we;
  logic                 tap_valid;
  logic [XW-1:0]        buffer [N];
  logic [6:0][XW-1:0]   taps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      issue_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      issue_idx_q <= issue_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    issue_idx_d = issue_idx_q;
    buf_we      = 1'b0;
    tap_valid   = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_idx_d = '0;
            state_d  = CALC;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      CALC: begin
        tap_valid = 1'b1;
        if (issue_idx_q == LAST) begin
          issue_idx_d = '0;
          state_d     = LOAD;
        end else begin
          issue_idx_d = issue_idx_q + 1'b1;
        end
      end
    endcase
  end

  assign busy = (state_q == CALC);

  // Buffer is only written in LOAD, so CALC-time in_valid cannot disturb it.
  always_ff @(posedge clk) begin
    if (buf_we) buffer[wr_idx_q] <= x_in;
  end

  // Taps beyond either end of the vector read as zero.
  for (genvar g = 0; g < 7; g++) begin : g_tap
    logic signed [IW+1:0] pos;
    assign pos = $signed({2'b00, issue_idx_q}) + (IW+2)'(g - 3);
    assign taps[g] = (!pos[IW+1] && (pos < $signed((IW+2)'(N)))) ? buffer[pos[IW-1:0]] : '0;
  end

  band_row_pipe #(
    .XW(XW),
    .BW(BW)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .tap_valid(tap_valid),
    .taps     (taps),
    .b_out    (b_out),
    .out_valid(out_valid)
  );

endmodule
